sum_double_pipe: RTL and testbench

//  Streaming two-stage arithmetic pipeline: stage 1 computes sum = x + y, stage 2 computes
//  dbl = sum * 2, both via internal functions. Sits directly downstream of the operand

---
 rtl/sum_double_pipe.sv | 151 +++++++++++++++
 tb/tb_sum_double_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_double_pipe.sv
// Two-stage (x+y)*2 streaming pipeline with a 2-entry output skid buffer and acceptance counter.
// Define SUM_DOUBLE_SAT_EN to saturate each stage to all-ones instead of wrapping.
module sum_double_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dbl,
  output logic             out_ovf,
  output logic [CNT_W-1:0] acc_cnt
);

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_e;

  // Each function returns {overflow, value}.
  function automatic logic [WIDTH:0] f_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SUM_DOUBLE_SAT_EN
    if (s[WIDTH]) s[WIDTH-1:0] = '1;
`endif
    return s;
  endfunction

  function automatic logic [WIDTH:0] f_dbl(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] d;
    d = {v, 1'b0};
`ifdef SUM_DOUBLE_SAT_EN
    if (d[WIDTH]) d[WIDTH-1:0] = '1;
`endif
    return d;
  endfunction

  function automatic logic [2:0] f_skid_cnt(input skid_e s);
    case (s)
      SKID_ONE: return 3'd1;
      SKID_TWO: return 3'd2;
      default:  return 3'd0;
    endcase
  endfunction

  logic             r_s1_v, r_s2_v;
  logic [WIDTH-1:0] r_s1_val, r_s2_val;
  logic             r_s1_ovf, r_s2_ovf;
  logic [WIDTH-1:0] r_skid_val [2];
  logic             r_skid_ovf [2];
  logic             r_skid_rd, r_skid_wr;
  skid_e            r_skid_st;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_acc_cnt;

  logic             w_skid_ne;
  logic             w_pop, w_pop_skid, w_pop_s2, w_push;
  logic             w_s2_free, w_adv, w_s1_free, w_acc;
  logic             w_s1_v_next, w_s2_v_next;
  logic [2:0]       w_skid_cnt_next, w_occ_next;
  logic [WIDTH:0]   w_sum, w_dbl;

  assign in_ready  = r_in_ready;
  assign acc_cnt   = r_acc_cnt;
  assign w_skid_ne = (r_skid_st != SKID_EMPTY);

  // The skid entries are always older than stage 2, so they are presented first.
  assign out_valid = w_skid_ne | r_s2_v;
  assign out_dbl   = w_skid_ne ? r_skid_val[r_skid_rd] : r_s2_val;
  assign out_ovf   = w_skid_ne ? r_skid_ovf[r_skid_rd] : r_s2_ovf;

  assign w_sum = f_sum(in_x, in_y);
  assign w_dbl = f_dbl(r_s1_val);

  always_comb begin
    w_pop      = out_valid & out_ready;
    w_pop_skid = w_pop & w_skid_ne;
    w_pop_s2   = w_pop & ~w_skid_ne;
    w_push     = r_s2_v & ~w_pop_s2 & ((r_skid_st != SKID_TWO) | w_pop_skid);
    w_s2_free  = ~r_s2_v | w_pop_s2 | w_push;
    w_adv      = r_s1_v & w_s2_free;
    w_s1_free  = ~r_s1_v | w_adv;
    w_acc      = in_valid & r_in_ready;
    w_s1_v_next     = w_acc | (r_s1_v & ~w_adv);
    w_s2_v_next     = w_adv | (r_s2_v & ~w_pop_s2 & ~w_push);
    w_skid_cnt_next = f_skid_cnt(r_skid_st) + {2'b00, w_push} - {2'b00, w_pop_skid};
    w_occ_next      = {2'b00, w_s1_v_next} + {2'b00, w_s2_v_next} + w_skid_cnt_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s1_val   <= '0;
      r_s2_val   <= '0;
      r_s1_ovf   <= 1'b0;
      r_s2_ovf   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_skid_val[i] <= '0;
        r_skid_ovf[i] <= 1'b0;
      end
      r_skid_rd  <= 1'b0;
      r_skid_wr  <= 1'b0;
      r_skid_st  <= SKID_EMPTY;
      r_in_ready <= 1'b1;
      r_acc_cnt  <= '0;
    end else begin
      r_s1_v <= w_s1_v_next;
      r_s2_v <= w_s2_v_next;
      if (w_acc) begin
        r_s1_val  <= w_sum[WIDTH-1:0];
        r_s1_ovf  <= w_sum[WIDTH];
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_adv) begin
        r_s2_val <= w_dbl[WIDTH-1:0];
        r_s2_ovf <= r_s1_ovf | w_dbl[WIDTH];
      end
      if (w_push) begin
        r_skid_val[r_skid_wr] <= r_s2_val;
        r_skid_ovf[r_skid_wr] <= r_s2_ovf;
        r_skid_wr             <= ~r_skid_wr;
      end
      if (w_pop_skid) r_skid_rd <= ~r_skid_rd;
      case (r_skid_st)
        SKID_EMPTY: if (w_push && !w_pop_skid) r_skid_st <= SKID_ONE;
        SKID_ONE: begin
          if (w_push && !w_pop_skid)      r_skid_st <= SKID_TWO;
          else if (w_pop_skid && !w_push) r_skid_st <= SKID_EMPTY;
        end
        SKID_TWO: if (w_pop_skid && !w_push) r_skid_st <= SKID_ONE;
        default: r_skid_st <= SKID_EMPTY;
      endcase
      // Registered ready: admit only while total occupancy stays within four slots.
      r_in_ready <= (w_occ_next < 3'd4);
    end
  end

  a_no_overwrite: assert property (@(posedge clk) disable iff (rst) w_acc |-> w_s1_free);
  a_no_skid_ovf:  assert property (@(posedge clk) disable iff (rst)
                                   w_push |-> ((r_skid_st != SKID_TWO) || w_pop_skid));
  a_occ_bound:    assert property (@(posedge clk) disable iff (rst) w_occ_next <= 3'd4);

endmodule

// File: tb/tb_sum_double_pipe.sv
// Self-checking bench for sum_double_pipe: spec-level queue model plus directed literal vectors.
module tb_sum_double_pipe;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_x = '0;
  logic [W-1:0]     in_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_dbl;
  logic             out_ovf;
  logic [CNT_W-1:0] acc_cnt;

  sum_double_pipe #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_dbl(out_dbl), .out_ovf(out_ovf), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dbl;
    int ovf;
    int n;
    bit has_lit;
    int lit_dbl;
    int lit_ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mcnt = 0;
  bit   armed = 0;
  bit   rand_bp = 0;
  bit   lit_en = 0;
  int   lit_d = 0;
  int   lit_o = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Result of (x+y)*2 by the width rules, computed with plain integers.
  function automatic void model(input int x, input int y, output int d, output int o);
    int s, t, dd, o1, o2;
    s  = x + y;
    o1 = (s > MAXV) ? 1 : 0;
    t  = s % (MAXV + 1);
`ifdef SUM_DOUBLE_SAT_EN
    if (o1 != 0) t = MAXV;
`endif
    dd = t * 2;
    o2 = (dd > MAXV) ? 1 : 0;
    d  = dd % (MAXV + 1);
`ifdef SUM_DOUBLE_SAT_EN
    if (o2 != 0) d = MAXV;
`endif
    o = o1 | o2;
  endfunction

  // Compare process: every cycle, outputs against the queue model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (armed) begin
        bit exp_v;
        chk("in_ready", in_ready, (q.size() < 4) ? 1 : 0);
        chk("acc_cnt", acc_cnt, mcnt);
        exp_v = (q.size() > 0) && (cyc >= q[0].n + 2);
        chk("out_valid", out_valid, exp_v);
        if (exp_v && out_valid) begin
          chk("out_dbl", out_dbl, q[0].dbl);
          chk("out_ovf", out_ovf, q[0].ovf);
          if (q[0].has_lit) begin
            chk("lit_dbl", out_dbl, q[0].lit_dbl);
            chk("lit_ovf", out_ovf, q[0].lit_ovf);
          end
        end
      end
      if (rst) begin
        q.delete();
        mcnt = 0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          exp_t e;
          model(int'(in_x), int'(in_y), e.dbl, e.ovf);
          e.n = cyc;
          e.has_lit = lit_en;
          e.lit_dbl = lit_d;
          e.lit_ovf = lit_o;
          q.push_back(e);
          mcnt = (mcnt + 1) % (1 << CNT_W);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the pair is taken.
  task automatic send(input int x, input int y, input bit le, input int ld, input int lo);
    bit ok = 0;
    in_x = W'(x); in_y = W'(y);
    lit_en = le; lit_d = ld; lit_o = lo;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_en = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int e3, e4;
`ifdef SUM_DOUBLE_SAT_EN
    e3 = 255; e4 = 255;
`else
    e3 = 88;  e4 = 24;
`endif
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    chk("rst_out_dbl", out_dbl, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(posedge clk);
    #1;

    // Basic, wrap/saturate boundaries
    out_ready = 1'b1;
    send(1, 2, 1, 6, 0);
    send(200, 100, 1, e3, 1);
    send(100, 40, 1, e4, 1);
    send(255, 255, 0, 0, 0);
    send(127, 0, 0, 0, 0);
    drain();
    @(negedge clk);
    chk("acc_after_basic", acc_cnt, 5);
    @(posedge clk);
    #1;

    // Backpressure: four admitted, then results in order
    do_reset();
    out_ready = 1'b0;
    fork
      for (int k = 1; k <= 10; k++) send(k, 0, 1, 2 * k, 0);
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("stall_acc_cnt", acc_cnt, 4);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_dbl", out_dbl, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    chk("stream_acc_cnt", acc_cnt, 10);
    @(posedge clk);
    #1;

    // Random backpressure, then reset with data in flight
    do_reset();
    rand_bp = 1;
    for (int k = 0; k < 1000; k++) send(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), 0, 0, 0);
    send(9, 9, 0, 0, 0);
    send(10, 10, 0, 0, 0);
    do_reset();
    rand_bp = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_acc_cnt", acc_cnt, 0);
    end
    @(posedge clk);
    #1;
    send(5, 6, 1, 22, 0);
    drain();
    @(negedge clk);
    chk("post_rst_acc_one", acc_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
